// File: rtl/fp_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_adder_arbiter
// Purpose  : Round-robin arbiter/sequencer that time-shares one multicycle
//            floating-point adder among NUM_REQ requesters. One operation is
//            in flight at a time; each result is returned to its originator
//            with a one-cycle response strobe.
// Options  : FPADD_ARB_TIMEOUT_EN - abort a WAIT that outlasts TIMEOUT_CYCLES,
//            return an error response, then re-enter holdoff.
// Revision : 1.0 - initial release
// ============================================================================
module fp_adder_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int EXP_LEN        = 8,
    parameter int MANTISSA_LEN   = 23,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int W             = EXP_LEN + MANTISSA_LEN + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [W-1:0]         rsp_sum,
    output logic                 rsp_error,
    output logic [W-1:0]         adder_a,
    output logic [W-1:0]         adder_b,
    output logic                 adder_start,
    input  logic [W-1:0]         adder_sum,
    input  logic                 adder_done,
    output logic                 busy
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HCNT_W = $clog2(HOLDOFF_CYCLES + 1);

    typedef enum logic [2:0] {
        S_HOLDOFF = 3'd0,
        S_IDLE    = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [HCNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [W-1:0]        sum_q, sum_d;
    logic                busy_q, busy_d;

    logic                grant_found;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    cand;
    logic                transfer;

`ifdef FPADD_ARB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic                err_q, err_d;
`else
    // Timeout length only matters in the timeout build.
    logic                unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign req_ready   = (state_q == S_IDLE && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;
    assign transfer    = |(req_valid & req_ready);
    assign rsp_valid   = (state_q == S_RESP) ? (NUM_REQ'(1) << idx_q) : '0;
    assign adder_start = (state_q == S_ISSUE);
    assign adder_a     = a_q;
    assign adder_b     = b_q;
    assign rsp_sum     = sum_q;
    assign busy        = busy_q;
`ifdef FPADD_ARB_TIMEOUT_EN
    assign rsp_error   = err_q;
`else
    assign rsp_error   = 1'b0;
`endif

    // Next-state and datapath update for the sequencer FSM.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
`ifdef FPADD_ARB_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_HOLDOFF: begin
                if (hold_cnt_q == HCNT_W'(HOLDOFF_CYCLES - 1)) begin
                    state_d    = S_IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (transfer) begin
                    idx_d   = grant_idx;
                    a_d     = req_a[grant_idx*W +: W];
                    b_d     = req_b[grant_idx*W +: W];
                    ptr_d   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef FPADD_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                // A done pulse wins over a coincident timeout.
                if (adder_done) begin
                    sum_d   = adder_sum;
                    state_d = S_RESP;
`ifdef FPADD_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (tmo_cnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    sum_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
`ifdef FPADD_ARB_TIMEOUT_EN
                // After an abort the adder may still be busy; let it drain.
                if (err_q) begin
                    state_d    = S_HOLDOFF;
                    hold_cnt_d = '0;
                end
`endif
            end
            default: begin
                state_d    = S_HOLDOFF;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HOLDOFF;
            hold_cnt_q <= '0;
            ptr_q      <= '0;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            busy_q     <= 1'b0;
`ifdef FPADD_ARB_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            busy_q     <= busy_d;
`ifdef FPADD_ARB_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_adder_arbiter
// Purpose  : Scoreboard bench for fp_adder_arbiter with a behavioural adder
//            model, a round-robin reference and randomized requester traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_adder_arbiter;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int HOLD = 16;
    localparam int TO   = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid, req_ready, rsp_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   rsp_sum, adder_a, adder_b, adder_sum;
    logic           rsp_error, adder_start, adder_done, busy;
    logic           done_model, spur, spur_idle;

    assign adder_done = done_model | spur;

    always #5 clk = ~clk;

    fp_adder_arbiter #(
        .NUM_REQ(N), .EXP_LEN(8), .MANTISSA_LEN(23),
        .HOLDOFF_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_error(rsp_error),
        .adder_a(adder_a), .adder_b(adder_b), .adder_start(adder_start),
        .adder_sum(adder_sum), .adder_done(adder_done), .busy(busy)
    );

    typedef struct {
        int         idx;
        logic [W-1:0] sum;
        logic       err;
        int         acc;
    } exp_t;

    exp_t   sb[$];
    int     grant_log[$];
    int     cyc = 0;
    int     n_chk = 0, n_pass = 0;
    int     mptr = 0, acc_cyc = 0, done_cyc = 0;
    bit     never_done = 0, rand_lat = 0, spur_en = 0, auto_en = 0;
    int     lat = 6, remaining = 0, drop_pct = 0, retract_pct = 0;
    bit [N-1:0] accepted = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Stand-in adder: a few exact IEEE single-precision sums, integer sum otherwise.
    function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'h3F80_0000 && b == 32'hBF80_0000) return 32'h0000_0000;
        if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4080_0000;
        return a + b;
    endfunction

    // Accept monitor: reference round-robin grant, push expected response.
    logic [N-1:0] exp_g;
    int           gi, jj;
    exp_t         ne;
    always @(negedge clk) begin
        if (rst_n && req_ready != '0) begin
            exp_g = '0;
            gi    = -1;
            for (int k = 0; k < N; k++) begin
                jj = (mptr + k) % N;
                if (gi < 0 && req_valid[jj]) gi = jj;
            end
            if (gi >= 0) exp_g[gi] = 1'b1;
            chk("grant", req_ready, exp_g);
            chk("one_in_flight", sb.size(), 0);
            if ((req_valid & req_ready) != '0 && gi >= 0) begin
                ne.idx = gi;
                ne.sum = never_done ? '0 : ref_add(req_a[gi*W +: W], req_b[gi*W +: W]);
                ne.err = never_done;
                ne.acc = cyc;
                sb.push_back(ne);
                acc_cyc = cyc;
                mptr    = (gi + 1) % N;
                grant_log.push_back(gi);
                accepted[gi] = 1'b1;
            end
        end
    end

    // Response monitor: pop and compare whenever any rsp_valid bit is set.
    exp_t re;
    always @(negedge clk) begin
        if (rst_n && rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", rsp_valid, 0);
            end else begin
                re = sb.pop_front();
                chk("rsp_dest", rsp_valid, N'(1) << re.idx);
                chk("rsp_sum", rsp_sum, re.sum);
                chk("rsp_error", rsp_error, re.err);
                if (re.err) chk("rsp_cycle_timeout", cyc, re.acc + TO + 2);
                else        chk("rsp_cycle", cyc, done_cyc + 1);
            end
        end
    end

    // Adder model: done L cycles after start, with the operands seen at start.
    logic [W-1:0] ma, mb;
    int           ml;
    initial begin
        done_model = 1'b0;
        adder_sum  = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && adder_start) begin
                chk("start_latency", cyc, acc_cyc + 1);
                ma = adder_a;
                mb = adder_b;
                if (!never_done) begin
                    ml = rand_lat ? int'($urandom_range(1, 8)) : lat;
                    repeat (ml) @(posedge clk);
                    #1;
                    done_model = 1'b1;
                    adder_sum  = ref_add(ma, mb);
                    done_cyc   = cyc;
                    @(posedge clk); #1;
                    done_model = 1'b0;
                    adder_sum  = $urandom;
                end
            end
        end
    end

    // Spurious done injector: during ISSUE/RESP when enabled, or on request.
    initial begin
        spur = 1'b0;
        forever begin
            @(posedge clk); #2;
            spur = (spur_en && (adder_start || rsp_valid != '0)) || spur_idle;
        end
    end

    task automatic load(input int i);
        req_a[i*W +: W] = $urandom;
        req_b[i*W +: W] = $urandom;
        if ($urandom_range(0, 9) == 0) begin
            req_a[i*W +: W] = 32'h4000_0000;
            req_b[i*W +: W] = 32'h4000_0000;
        end
    endtask

    // Randomized requester traffic.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (auto_en) begin
                for (int i = 0; i < N; i++) begin
                    if (accepted[i]) begin
                        accepted[i] = 1'b0;
                        if (remaining > 0 && int'($urandom_range(0, 99)) >= drop_pct) begin
                            load(i);
                            remaining--;
                        end else begin
                            req_valid[i] = 1'b0;
                        end
                    end else if (!req_valid[i] && remaining > 0 && $urandom_range(0, 99) < 40) begin
                        load(i);
                        req_valid[i] = 1'b1;
                        remaining--;
                    end else if (req_valid[i] && int'($urandom_range(0, 99)) < retract_pct) begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        mptr     = 0;
        accepted = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Counts cycles without a grant after reset release.
    task automatic holdoff_check(input string name, input logic [N-1:0] exp_grant);
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (req_ready != '0) break;
            n++;
        end
        chk(name, n, HOLD);
        chk({name, "_grant"}, req_ready, exp_grant);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (!(req_valid == '0 && sb.size() == 0 && !busy) && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        chk({name, "_drain"}, t < 5000, 1);
    endtask

    task automatic wait_rsp(input string name);
        int t;
        t = 0;
        while (rsp_valid == '0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_rsp_seen"}, t < 200, 1);
    endtask

    task automatic wait_start(input string name);
        int t;
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!adder_start && t < 200);
        chk({name, "_start_seen"}, t < 200, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        spur_idle = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_adder_start", adder_start, 0);
        chk("reset_busy", busy, 0);
        chk("reset_adder_a", adder_a, 0);
        chk("reset_rsp_sum", rsp_sum, 0);

        // Directed 1.0 + 2.0 with a 6-cycle adder.
        lat = 6;
        req_a[0 +: W] = 32'h3F80_0000;
        req_b[0 +: W] = 32'h4000_0000;
        req_valid = 4'b0001;
        rst_n = 1'b1;
        holdoff_check("holdoff", 4'b0001);
        wait_rsp("directed");
        @(negedge clk);
        chk("ready_after_rsp", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        drain("directed");

        // All four requesters continuously valid: order 0,1,2,3,0.
        for (int i = 0; i < N; i++) load(i);
        req_a[1*W +: W] = 32'h3F80_0000;
        req_b[1*W +: W] = 32'hBF80_0000;
        req_valid   = 4'b1111;
        drop_pct    = 0;
        retract_pct = 0;
        remaining   = 4;
        grant_log.delete();
        rst_n = 1'b0;
        sb.delete();
        mptr     = 0;
        accepted = '0;
        @(posedge clk); #1;
        auto_en = 1'b1;
        rst_n   = 1'b1;
        holdoff_check("holdoff_rr", 4'b0001);
        begin
            int t;
            t = 0;
            while (grant_log.size() < 5 && t < 1000) begin
                @(posedge clk); #1;
                t++;
            end
            chk("rr_grants_seen", t < 1000, 1);
        end
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) chk("rr_order", grant_log[k], k % 4);
        end
        remaining = 0;
        drain("rr");

        // Spurious done in IDLE, then in ISSUE and RESP during live traffic.
        spur_idle = 1'b1;
        @(posedge clk); #1;
        spur_idle = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_spur_busy", busy, 0);
        spur_en     = 1'b1;
        drop_pct    = 20;
        remaining   = 8;
        drain("spur");
        spur_en     = 1'b0;

        // Randomized traffic with random adder latency and retracting requesters.
        rand_lat    = 1'b1;
        drop_pct    = 30;
        retract_pct = 3;
        remaining   = 60;
        drain("random");
        rand_lat    = 1'b0;
        auto_en     = 1'b0;
        retract_pct = 0;

        // Adder never completes.
        never_done = 1'b1;
        req_a[2*W +: W] = $urandom;
        req_b[2*W +: W] = $urandom;
        req_valid = 4'b0100;
        wait_start("nodone");
        req_valid = '0;
`ifdef FPADD_ARB_TIMEOUT_EN
        wait_rsp("timeout");
        repeat (16) @(negedge clk);
        chk("timeout_holdoff_busy", busy, 1);
        @(negedge clk);
        chk("timeout_holdoff_end", busy, 0);
`else
        repeat (40) @(posedge clk);
        #1;
        chk("nodone_stuck_busy", busy, 1);
`endif
        never_done = 1'b0;

        // Reset pulsed during WAIT; late done lands in holdoff.
        do_reset();
        drain("pre_abort");
        lat = 10;
        req_a[2*W +: W] = 32'h4000_0000;
        req_b[2*W +: W] = 32'h4000_0000;
        req_valid = 4'b0100;
        wait_start("abort");
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_req_ready", req_ready, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_adder_start", adder_start, 0);
        chk("abort_adder_a", adder_a, 0);
        chk("abort_adder_b", adder_b, 0);
        chk("abort_rsp_sum", rsp_sum, 0);
        chk("abort_rsp_error", rsp_error, 0);
        chk("abort_busy", busy, 0);
        sb.delete();
        mptr = 0;
        @(posedge clk); #1;
        lat = 3;
        req_a[2*W +: W] = 32'h3F80_0000;
        req_b[2*W +: W] = 32'h4000_0000;
        req_valid = 4'b0100;
        rst_n = 1'b1;
        holdoff_check("holdoff_abort", 4'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        drain("post_abort");

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_adder_arbiter.md
# fp_adder_arbiter

Round-robin arbiter and sequencer that shares one multicycle floating-point adder among `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues one start pulse per accepted pair to the adder. It then waits for the adder's done pulse and returns the sum to the originating requester with a one-cycle response strobe. It sits between the lattice-arithmetic clients and the single shared adder instance.

## Interface
- `NUM_REQ`, 4: number of requesters (2–16).
- `EXP_LEN`, 8: exponent width.
- `MANTISSA_LEN`, 23: stored mantissa width; W = EXP_LEN+MANTISSA_LEN+1.
- `HOLDOFF_CYCLES`, 16: idle cycles forced after reset or abort so a stale adder operation drains.
- `TIMEOUT_CYCLES`, 16: WAIT cycles before abort (timeout build only).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `req_valid` in NUM_REQ: requester i has an operand pair pending.
- `req_ready` out NUM_REQ: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_a`, `req_b` in NUM_REQ*W: operands; requester i occupies bits [i*W +: W].
- `rsp_valid` out NUM_REQ: one-cycle strobe to the originating requester. There is no backpressure on responses.
- `rsp_sum` out W: result, valid while any `rsp_valid` bit is set.
- `rsp_error` out 1: result aborted by timeout. Qualified by `rsp_valid`.
- `adder_a`, `adder_b` out W: registered operands to the adder.
- `adder_start` out 1: one-cycle start pulse to the adder.
- `adder_sum` in W: adder result.
- `adder_done` in 1: adder one-cycle done pulse.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: HOLDOFF, IDLE, ISSUE, WAIT, RESP.
- **Reset:** all outputs 0, round-robin pointer 0, state HOLDOFF, holdoff counter 0. Assertion mid-operation aborts immediately. The lost transaction produces no response.
- **HOLDOFF:**
  - Counts to HOLDOFF_CYCLES-1, then goes to IDLE.
  - `req_ready` = 0.
  - `adder_done` is ignored.
- **IDLE:**
  - Grant is combinational: the first requester with `req_valid` set, searching from the pointer upward with wrap.
  - `req_ready` = that grant (zero if no request).
  - On transfer, latch the index, `req_a` and `req_b`, and go to ISSUE.
  - Pointer ← granted index + 1, modulo NUM_REQ.
- **ISSUE:**
  - `adder_start` = 1 for exactly this cycle.
  - `adder_a` and `adder_b` are driven from the latch. They stay stable until the next ISSUE.
  - Go to WAIT.
- **WAIT:**
  - On `adder_done`, capture `adder_sum` into `rsp_sum`, clear `rsp_error`, and go to RESP.
  - `adder_done` is sampled only in WAIT; pulses in any other state are ignored.
- **RESP:**
  - `rsp_valid[idx]` = 1 for this cycle only.
  - Go to IDLE.
- `rsp_sum` holds its last value outside RESP.
- `req_ready` is zero in every state except IDLE, so at most one transaction is in flight.

## Timing
- Let T be the accept cycle, with the transfer in IDLE.
- T+1: `adder_start` high.
- First possible `adder_done` at T+2, in WAIT.
- If `adder_done` arrives in cycle D: `rsp_valid` at D+1, IDLE at D+2.
- A new transfer is possible at D+2. Back-to-back throughput is one operation per (adder latency + 3) cycles.
- After `rst_n` deasserts, the first `req_ready` appears at cycle HOLDOFF_CYCLES.
- `req_valid` dropping in IDLE before a transfer: no state change. The pointer advances only on a transfer.

## Configuration
- `FPADD_ARB_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs, reset on entry to WAIT.
  - When it reaches TIMEOUT_CYCLES without `adder_done`, go to RESP with `rsp_sum` = 0 and `rsp_error` = 1.
  - After that RESP, go to HOLDOFF instead of IDLE.
  - `adder_done` in the same cycle as the timeout takes priority: normal result.
- `FPADD_ARB_TIMEOUT_EN` undefined:
  - No counter.
  - WAIT waits indefinitely.
  - `rsp_error` is tied to 0.

## Test plan
- Reset release with `req_valid` = 4'b0001: `req_ready` stays 0 for 16 cycles, then grants requester 0.
- Requester 0 sends 0x3F800000 + 0x40000000; the adder model returns done 6 cycles after start: `adder_start` at T+1, then `rsp_valid` = 4'b0001 with `rsp_sum` = 0x40400000 one cycle after done, then `req_ready` at the following cycle.
- All four requesters hold `req_valid` continuously: grants occur in order 0, 1, 2, 3, 0. Each response goes only to its own index; 0x3F800000 + 0xBF800000 returns 0x00000000.
- A spurious `adder_done` pulse is injected in IDLE and in ISSUE: no `rsp_valid`, state unaffected. A spurious pulse in RESP is also ignored.
- Timeout build, adder model never asserts done: `rsp_valid` with `rsp_error` = 1 and `rsp_sum` = 0 at T+1+TIMEOUT_CYCLES+1, then a 16-cycle holdoff. Non-timeout build: `busy` stays high indefinitely.
- `rst_n` pulsed low during WAIT: all outputs 0 asynchronously, no response for the lost request, holdoff restarts. A late `adder_done` during holdoff is ignored.
